// File: rtl/mem_port_arbiter_if.sv
// Bus bundle joining the fetch and load/store masters, the port arbiter and the memory macro.
interface mem_port_arbiter_if #(
    parameter int N = 32
);
    logic         i_req;
    logic [N-1:0] i_addr;
    logic         i_ack;
    logic [N-1:0] i_rdata;
    logic         d_req;
    logic         d_we;
    logic [N-1:0] d_addr;
    logic [N-1:0] d_wdata;
    logic         d_ack;
    logic [N-1:0] d_rdata;
    logic         err;
    logic         mem_en;
    logic         mem_we;
    logic [N-1:0] mem_addr;
    logic [N-1:0] mem_wdata;
    logic [N-1:0] mem_rdata;
    logic         mem_ready;
    logic         busy;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output i_ack, i_rdata, d_ack, d_rdata, err, mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  i_ack, i_rdata, d_ack, d_rdata, err, mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch and load/store,
// with variable memory latency and a bounded wait that aborts with err.
module mem_port_arbiter #(
    parameter int N       = 32,
    parameter int TIMEOUT = 16
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic          PORT_I   = 1'b0;
    localparam logic          PORT_D   = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_grant_q, last_grant_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          mem_we_q, mem_we_d;
    logic [N-1:0]  mem_addr_q, mem_addr_d;
    logic [N-1:0]  mem_wdata_q, mem_wdata_d;
    logic [N-1:0]  i_rdata_q, i_rdata_d;
    logic [N-1:0]  d_rdata_q, d_rdata_d;
    logic          grant, grant_port, timeout_hit;

    // On a tie the port that did not win last time is served.
    always_comb begin
        grant       = bus.i_req | bus.d_req;
        grant_port  = (bus.i_req && bus.d_req) ? ~last_grant_q : bus.d_req;
        timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant) state_d = ACCESS;
            ACCESS:  if (bus.mem_ready || timeout_hit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    owner_d      = grant_port;
                    last_grant_d = grant_port;
                    cnt_d        = '0;
                    if (grant_port == PORT_D) begin
                        mem_addr_d = bus.d_addr;
                        mem_we_d   = bus.d_we;
                        if (bus.d_we) mem_wdata_d = bus.d_wdata;
                    end else begin
                        mem_addr_d = bus.i_addr;
                        mem_we_d   = 1'b0;
                    end
                end
            end
            ACCESS: begin
                // A ready in the last allowed cycle still completes normally.
                if (bus.mem_ready) begin
                    err_d = 1'b0;
                    if (owner_q == PORT_I) i_rdata_d = bus.mem_rdata;
                    else if (!mem_we_q)    d_rdata_d = bus.mem_rdata;
                end else if (timeout_hit) begin
                    err_d = 1'b1;
                    if (owner_q == PORT_I) i_rdata_d = '0;
                    else                   d_rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q      <= PORT_I;
            last_grant_q <= PORT_D;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    // Strobes decode from state alone so an async reset drops them at once.
    always_comb begin
        bus.mem_en    = (state_q == ACCESS);
        bus.mem_we    = (state_q == ACCESS) && mem_we_q;
        bus.i_ack     = (state_q == RESP) && (owner_q == PORT_I);
        bus.d_ack     = (state_q == RESP) && (owner_q == PORT_D);
        bus.err       = (state_q == RESP) && err_q;
        bus.busy      = (state_q != IDLE);
        bus.mem_addr  = mem_addr_q;
        bus.mem_wdata = mem_wdata_q;
        bus.i_rdata   = i_rdata_q;
        bus.d_rdata   = d_rdata_q;
    end
endmodule
